// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: probes the I-cache, refills it from memory on a miss.
// Optional lookup counters are enabled with `define IFETCH_PERF_EN.
module ifetch_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [29:0] fetch_addr,
  output logic        fetch_resp_valid,
  input  logic        fetch_resp_ready,
  output logic [31:0] fetch_resp_data,
  output logic        ic_req_valid,
  output logic        ic_wen,
  output logic [29:0] ic_addr,
  output logic [31:0] ic_wdata,
  input  logic        ic_is_hit,
  input  logic [31:0] ic_rdata,
  input  logic        ic_resp_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t      state_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        ic_req_q;
  logic        ic_wen_q;
  logic        mem_req_q;

  // Control flags are set on the same edge as the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 30'd0;
      data_q       <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      ic_req_q     <= 1'b0;
      ic_wen_q     <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req_valid) begin
            addr_q      <= fetch_addr;
            req_ready_q <= 1'b0;
            ic_req_q    <= 1'b1;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          ic_req_q <= 1'b0;
          if (ic_is_hit) begin
            data_q       <= ic_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            data_q   <= mem_resp_data;
            ic_wen_q <= 1'b1;
            state_q  <= FILL;
          end
        end
        FILL: begin
          ic_wen_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (fetch_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          ic_req_q     <= 1'b0;
          ic_wen_q     <= 1'b0;
          mem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req_ready  = req_ready_q;
  assign fetch_resp_valid = resp_valid_q;
  assign fetch_resp_data  = data_q;
  assign ic_req_valid     = ic_req_q;
  assign ic_wen           = ic_wen_q;
  assign ic_addr          = addr_q;
  assign ic_wdata         = data_q;
  assign mem_req_valid    = mem_req_q;
  assign mem_addr         = {addr_q, 2'b00};

  // The cache response strobe is informational only.
  logic unused_ic_resp_s;
  assign unused_ic_resp_s = ic_resp_valid;

`ifdef IFETCH_PERF_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // One count per LOOKUP cycle, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= 32'd0;
      miss_q <= 32'd0;
    end else if (state_q == LOOKUP) begin
      if (ic_is_hit) begin
        hit_q <= hit_q + 32'd1;
      end else begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a small direct-mapped cache model (1024 lines).
module tb_ifetch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req_valid = 1'b0;
  logic        fetch_req_ready;
  logic [29:0] fetch_addr = 30'd0;
  logic        fetch_resp_valid;
  logic        fetch_resp_ready = 1'b1;
  logic [31:0] fetch_resp_data;
  logic        ic_req_valid;
  logic        ic_wen;
  logic [29:0] ic_addr;
  logic [31:0] ic_wdata;
  logic        ic_is_hit;
  logic [31:0] ic_rdata;
  logic        ic_resp_valid;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  logic cache_clr = 1'b1;

  logic [31:0] c_data  [1024];
  logic [19:0] c_tag   [1024];
  logic        c_valid [1024];

  ifetch_ctrl dut (
    .clock(clock), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_ready(fetch_resp_ready),
    .fetch_resp_data(fetch_resp_data),
    .ic_req_valid(ic_req_valid), .ic_wen(ic_wen), .ic_addr(ic_addr),
    .ic_wdata(ic_wdata), .ic_is_hit(ic_is_hit), .ic_rdata(ic_rdata),
    .ic_resp_valid(ic_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  assign ic_is_hit = ic_req_valid && !ic_wen && c_valid[ic_addr[9:0]] &&
                     (c_tag[ic_addr[9:0]] == ic_addr[29:10]);
  assign ic_rdata      = c_data[ic_addr[9:0]];
  assign ic_resp_valid = ic_req_valid;

  // Cache array: write completes at the FILL clock edge.
  always @(posedge clock) begin
    if (cache_clr) begin
      for (int i = 0; i < 1024; i++) c_valid[i] <= 1'b0;
    end else if (ic_wen) begin
      c_valid[ic_addr[9:0]] <= 1'b1;
      c_tag[ic_addr[9:0]]   <= ic_addr[29:10];
      c_data[ic_addr[9:0]]  <= ic_wdata;
    end
  end

  // Fill-pulse counter.
  always @(posedge clock) begin
    if (ic_wen) wen_cnt <= wen_cnt + 1;
    if (ic_wen && ic_req_valid) begin
      $display("FAIL excl ic_wen and ic_req_valid both high");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full fetch transaction; memory ready immediately, response k cycles after acceptance.
  task automatic do_fetch(input logic [31:0] baddr, input logic [31:0] data,
                          input bit exp_miss, input int k);
    int n;
    n = 0;
    while (!fetch_req_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_ready_wait", {31'd0, fetch_req_ready}, 32'd1);
    fetch_req_valid = 1'b1;
    fetch_addr      = baddr[31:2];
    tick();                               // edge N -> cycle N+1
    fetch_req_valid = 1'b0;
    check_eq("lookup_probe", {30'd0, ic_req_valid, ic_wen}, 32'd2);
    check_eq("lookup_ready", {31'd0, fetch_req_ready}, 32'd0);
    tick();                               // cycle N+2
    if (exp_miss) begin
      check_eq("miss_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check_eq("miss_addr", mem_addr, baddr);
      check_eq("miss_no_resp", {31'd0, fetch_resp_valid}, 32'd0);
      for (int i = 0; i < k; i++) tick();   // cycle N+2+K
      check_eq("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      tick();                             // cycle N+3+K: FILL
      mem_resp_valid = 1'b0;
      check_eq("fill_wen", {30'd0, ic_req_valid, ic_wen}, 32'd1);
      check_eq("fill_wdata", ic_wdata, data);
      check_eq("fill_addr", {ic_addr, 2'b00}, baddr);
      tick();                             // cycle N+4+K: RESP
    end else begin
      check_eq("hit_no_mem", {31'd0, mem_req_valid}, 32'd0);
    end
    check_eq("resp_valid", {31'd0, fetch_resp_valid}, 32'd1);
    check_eq("resp_data", fetch_resp_data, data);
    tick();
    check_eq("idle_ready", {31'd0, fetch_req_ready}, 32'd1);
    check_eq("idle_resp", {31'd0, fetch_resp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {26'd0, fetch_req_ready, fetch_resp_valid, ic_req_valid,
                             ic_wen, mem_req_valid, 1'b0}, 32'h20);
    check_eq({tag, "_memaddr"}, mem_addr, 32'd0);
    check_eq({tag, "_icaddr"}, {2'b00, ic_addr}, 32'd0);
    check_eq({tag, "_data"}, fetch_resp_data, 32'd0);
    check_eq({tag, "_wdata"}, ic_wdata, 32'd0);
    check_eq({tag, "_hits"}, hit_count, 32'd0);
    check_eq({tag, "_misses"}, miss_count, 32'd0);
  endtask

  initial begin
    int wen_snap;
    tick();
    tick();
    cache_clr = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Cold miss then hit.
    do_fetch(32'h0000_0100, 32'h0000_0013, 1'b1, 3);
    do_fetch(32'h0000_0100, 32'h0000_0013, 1'b0, 0);

    // Conflicts on the same index.
    do_fetch(32'h0000_1100, 32'h0000_000C, 1'b1, 1);
    do_fetch(32'h0000_0100, 32'h0000_000A, 1'b1, 2);
    do_fetch(32'h0000_1100, 32'h0000_000B, 1'b1, 1);
    do_fetch(32'h0000_0100, 32'h0000_000A, 1'b1, 4);

    // Memory and core backpressure, with a stray request while busy.
    mem_req_ready   = 1'b0;
    fetch_req_valid = 1'b1;
    fetch_addr      = 30'h80;               // byte 0x200
    tick();
    fetch_addr      = 30'h3FF;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_req", {31'd0, mem_req_valid}, 32'd1);
      check_eq("stall_addr", mem_addr, 32'h0000_0200);
      check_eq("stall_ready", {31'd0, fetch_req_ready}, 32'd0);
    end
    fetch_req_valid  = 1'b0;
    mem_req_ready    = 1'b1;
    fetch_resp_ready = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_valid", {31'd0, fetch_resp_valid}, 32'd1);
      check_eq("bp_data", fetch_resp_data, 32'h1234_5678);
      check_eq("bp_ready", {31'd0, fetch_req_ready}, 32'd0);
      tick();
    end
    fetch_resp_ready = 1'b1;
    tick();
    check_eq("bp_done", {31'd0, fetch_req_ready}, 32'd1);

`ifdef IFETCH_PERF_EN
    check_eq("hit_count", hit_count, 32'd1);
    check_eq("miss_count", miss_count, 32'd6);
`else
    check_eq("hit_count", hit_count, 32'd0);
    check_eq("miss_count", miss_count, 32'd0);
`endif

    // Reset while waiting on memory; the late response must be dropped.
    fetch_req_valid = 1'b1;
    fetch_addr      = 30'hC0;               // byte 0x300
    tick();
    fetch_req_valid = 1'b0;
    tick();
    tick();                                 // now in MISS_WAIT
    wen_snap = wen_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midrst");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_DEAD;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    check_reset_outputs("late_resp");
    check_eq("late_no_fill", wen_cnt, wen_snap);
    do_fetch(32'h0000_0300, 32'h0000_0055, 1'b1, 1);

`ifdef IFETCH_PERF_EN
    force dut.hit_q = 32'hFFFF_FFFF;
    tick();
    release dut.hit_q;
    do_fetch(32'h0000_0300, 32'h0000_0055, 1'b0, 0);
    check_eq("hit_wrap", hit_count, 32'd0);
`else
    do_fetch(32'h0000_0300, 32'h0000_0055, 1'b0, 0);
    check_eq("hit_off", hit_count, 32'd0);
    check_eq("miss_off", miss_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the core fetch port and the direct-mapped instruction cache. It accepts one word-aligned fetch at a time and probes the cache. On a miss it issues a single-word read to the memory bus, writes the returned word into the cache, and returns the instruction to the core. It is the only master of the cache's request and write ports.

## Interface
- No parameters; data 32 bits, word address 30 bits.
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fetch_req_valid  in  1  core fetch request
- fetch_req_ready  out  1  controller can accept a request; high only in IDLE
- fetch_addr  in  30  word address [31:2]
- fetch_resp_valid  out  1  instruction available
- fetch_resp_ready  in  1  core accepts instruction
- fetch_resp_data  out  32  instruction word
- ic_req_valid  out  1  cache read probe
- ic_wen  out  1  cache fill write
- ic_addr  out  30  cache word address
- ic_wdata  out  32  fill data
- ic_is_hit  in  1  combinational hit, valid while ic_req_valid && !ic_wen
- ic_rdata  in  32  combinational cache read data
- ic_resp_valid  in  1  cache response; monitored, not required for control
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  byte address {addr_q, 2'b00}
- mem_resp_valid  in  1  memory read data valid
- mem_resp_data  in  32  memory read data
- hit_count  out  32  lookup hits (see Configuration)
- miss_count  out  32  lookup misses (see Configuration)

## Operation
- State register with states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP.
- Holds addr_q (30 b) and data_q (32 b).
- IDLE: fetch_req_ready=1. On fetch_req_valid, latch fetch_addr into addr_q and go to LOOKUP.
- LOOKUP: ic_req_valid=1, ic_wen=0, ic_addr=addr_q.
  - ic_is_hit=1: data_q<=ic_rdata, go to RESP.
  - ic_is_hit=0: go to MISS_REQ.
- MISS_REQ: mem_req_valid=1, mem_addr={addr_q,2'b00}. Stay until mem_req_ready, then go to MISS_WAIT. mem_addr must stay stable while mem_req_valid is high.
- MISS_WAIT: on mem_resp_valid, data_q<=mem_resp_data and go to FILL. mem_resp_valid in any other state is ignored.
- FILL: one cycle. ic_wen=1, ic_req_valid=0, ic_addr=addr_q, ic_wdata=data_q. Then go to RESP.
- RESP: fetch_resp_valid=1, fetch_resp_data=data_q. Stay until fetch_resp_ready, then go to IDLE.
- All outputs not named for a state are 0. ic_addr=addr_q, ic_wdata=data_q and fetch_resp_data=data_q at all times.
- ic_req_valid and ic_wen are never both high.
- Only one request is outstanding. No speculative or next-line prefetch.
- A fill overwrites any line at the index regardless of the previous tag or valid bit.

## Timing
- Reset: state=IDLE, addr_q=0, data_q=0, counters=0. Outputs: fetch_req_ready=1; fetch_resp_valid=0, ic_req_valid=0, ic_wen=0, mem_req_valid=0; all data/address outputs 0.
- Request accepted at edge N (IDLE, fetch_req_valid=1):
  - LOOKUP is cycle N+1.
  - Hit: fetch_resp_valid high from cycle N+2.
- Miss timing, with memory ready immediately and response K≥1 cycles after request acceptance:
  - mem_req_valid in cycle N+2.
  - Response at cycle N+2+K; FILL at N+3+K.
  - fetch_resp_valid from N+4+K.
- Back-to-back fetches: the next request is accepted no earlier than the cycle after the RESP handshake. Minimum 3 cycles per hit.
- A re-fetch of a filled address hits, because the fill write completes at the FILL clock edge.
- Reset asserted in any state returns to IDLE at the next edge. An in-flight memory request is abandoned, and a late mem_resp_valid is ignored.
- fetch_req_valid while not IDLE is not accepted and has no effect.

## Configuration
- IFETCH_PERF_EN defined:
  - hit_count increments in each LOOKUP cycle with ic_is_hit=1; miss_count in each with ic_is_hit=0.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- IFETCH_PERF_EN undefined: hit_count and miss_count are tied to 0 and no counter flops exist. Functional behaviour is identical.

## Test plan
- Cold miss: after reset, fetch 0x0000_0100, memory returns 0x0000_0013 after K=3 → mem_addr=0x0000_0100, one FILL with ic_wdata=0x13, fetch_resp_data=0x13 at cycle N+7, miss_count=1.
- Hit after fill: re-fetch 0x0000_0100 → no mem_req_valid, fetch_resp_data=0x13 at N+2, hit_count=1.
- Conflict: fill 0x100 (data 0xA), then fetch 0x1100 (same index; data 0xB), then 0x100 → all three miss, responses 0xA, 0xB, 0xA.
- Backpressure: hold mem_req_ready=0 for 5 cycles, then fetch_resp_ready=0 for 4 cycles → mem_addr stable through the stall, fetch_resp_valid and fetch_resp_data held, fetch_req_ready=0 throughout.
- Reset mid-miss: assert reset in MISS_WAIT, then pulse mem_resp_valid with 0xDEAD → all outputs at reset values, no ic_wen pulse, next fetch to that address misses.
- Counter wrap (IFETCH_PERF_EN): force hit_count=0xFFFF_FFFF, perform one hit → hit_count=0. Without the macro, hit_count and miss_count read 0 throughout.
